mbledhesi_sekuencial: RTL and testbench

//  Multi-cycle parametrised adder/subtractor for the 16-bit CPU datapath.

---
 rtl/mbledhesi_sekuencial_if.sv | 26 ++
 rtl/mbledhesi_sekuencial.sv | 116 +++++++++++
 tb/tb_mbledhesi_sekuencial.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbledhesi_sekuencial_if.sv
// Operand/result bundle for the sequential adder/subtractor.
// A request is accepted on a rising edge where start=1 and ready=1; done then pulses for one cycle with result/flags valid.
interface mbledhesi_sekuencial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  ready, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output ready, done, result, carry_out, overflow, zero
  );
endinterface

// File: rtl/mbledhesi_sekuencial.sv
// Multi-cycle adder/subtractor: one SLICE-bit chunk per clock, LSB first.
// Optional result saturation on signed overflow: define MBLEDHESI_SAT_EN.
module mbledhesi_sekuencial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mbledhesi_sekuencial_if.slave bus,
  output logic [1:0]            dbg_state
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;

  logic             last;
  logic [SLICE:0]   chunk;
  logic [WIDTH+SLICE-1:0] sum_cat;
  logic [WIDTH-1:0] sum_nx;
  logic             ovf_nx;
  logic [WIDTH-1:0] res_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_RUN;
      S_RUN:   if (last)      state_nx = S_DONE;
      S_DONE:                 state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == S_IDLE);
    bus.done  = (state == S_DONE);
    dbg_state = state;
  end

  assign last    = (cnt == CW'(N - 1));
  assign chunk   = {1'b0, op_a[SLICE-1:0]} + {1'b0, op_b[SLICE-1:0]} + {{SLICE{1'b0}}, carry};
  // New chunk enters at the top; after N shifts the LSB chunk has reached bit 0.
  assign sum_cat = {chunk[SLICE-1:0], sum_sh};
  assign sum_nx  = sum_cat[WIDTH+SLICE-1:SLICE];
  assign ovf_nx  = (a_msb == b_msb) && (sum_nx[WIDTH-1] != a_msb);

`ifdef MBLEDHESI_SAT_EN
  always_comb begin
    res_nx = sum_nx;
    if (ovf_nx) res_nx = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res_nx = sum_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a          <= '0;
      op_b          <= '0;
      carry         <= 1'b0;
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      sum_sh        <= '0;
      cnt           <= '0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        // Subtraction is A + ~B + 1: invert B here, the +1 rides in as the initial carry.
        op_a   <= bus.a;
        op_b   <= bus.b ^ {WIDTH{bus.sub}};
        carry  <= bus.sub;
        a_msb  <= bus.a[WIDTH-1];
        b_msb  <= bus.b[WIDTH-1] ^ bus.sub;
        sum_sh <= '0;
        cnt    <= '0;
      end else if (state == S_RUN) begin
        op_a   <= op_a >> SLICE;
        op_b   <= op_b >> SLICE;
        carry  <= chunk[SLICE];
        sum_sh <= sum_nx;
        cnt    <= cnt + CW'(1);
        if (last) begin
          bus.result    <= res_nx;
          bus.carry_out <= chunk[SLICE];
          bus.overflow  <= ovf_nx;
          bus.zero      <= (res_nx == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mbledhesi_sekuencial.sv
// Randomised and directed bench for mbledhesi_sekuencial (WIDTH=16, SLICE=4).
module tb_mbledhesi_sekuencial;
  localparam int LAT = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_fail;
  logic [18:0] exp_q[$];

  mbledhesi_sekuencial_if #(.WIDTH(16)) bus ();

  mbledhesi_sekuencial #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: {result, carry, overflow, zero} from integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = s ? ua - ub : ua + ub;
    sr = s ? sa - sb : sa + sb;
    c  = s ? (ua >= ub) : (ur > 65535);
    v  = (sr > 32767) || (sr < -32768);
    r  = ur[15:0];
`ifdef MBLEDHESI_SAT_EN
    if (v) r = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {r, c, v, (r == 16'h0000)};
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] edge_vals[5];
    edge_vals = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // driver: one operation, scrambles inputs after the start edge, bounded wait for done
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int lat, output logic [18:0] got,
                        output logic ready_at_done, output logic ready_next, output logic done_next);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = s;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = 1'($urandom);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = {bus.result, bus.carry_out, bus.overflow, bus.zero};
    ready_at_done = bus.ready;
    @(negedge clk);
    ready_next = bus.ready;
    done_next  = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.result, bus.carry_out, bus.overflow, bus.zero} !== 19'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {bus.result, bus.carry_out, bus.overflow, bus.zero});
    end
    n_checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake: ready=%b done=%b required ready=1 done=0", bus.ready, bus.done);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: ready=%b done=%b", bus.ready, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta[6], tb_[6];
    logic        ts[6];
    logic [18:0] te[6];
    int lat; logic [18:0] got; logic rd, rn, dn;
    ta = '{16'h1234, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000, 16'h8000};
    tb_ = '{16'h4321, 16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h8000};
    ts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef MBLEDHESI_SAT_EN
    te = '{{16'h5555, 3'b000}, {16'h0000, 3'b101}, {16'hFFFE, 3'b000},
           {16'h7FFF, 3'b010}, {16'h8000, 3'b110}, {16'h8000, 3'b110}};
`else
    te = '{{16'h5555, 3'b000}, {16'h0000, 3'b101}, {16'hFFFE, 3'b000},
           {16'h8000, 3'b010}, {16'h7FFF, 3'b110}, {16'h0000, 3'b111}};
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb_[i], ts[i], lat, got, rd, rn, dn);
      n_checks++;
      if (got !== te[i]) begin
        n_fail++; $display("FAIL directed_%0d: got %h required %h", i, got, te[i]);
      end
      n_checks++;
      if (lat !== LAT || rd !== 1'b0) begin
        n_fail++; $display("FAIL directed_latency_%0d: latency %0d ready %b required %0d/0", i, lat, rd, LAT);
      end
      n_checks++;
      if (rn !== 1'b1 || dn !== 1'b0) begin
        n_fail++; $display("FAIL directed_return_%0d: ready %b done %b required 1/0", i, rn, dn);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [18:0] got, exp; logic rd, rn, dn;
    logic [15:0] a, b; logic s;
    for (int i = 0; i < 30; i++) begin
      a = pick(); b = pick(); s = 1'($urandom);
      exp_q.push_back(model(a, b, s));
      run_op(a, b, s, lat, got, rd, rn, dn);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random_%0d: %h %s %h got %h required %h", i, a, s ? "-" : "+", b, got, exp);
      end
      n_checks++;
      if (lat !== LAT || rn !== 1'b1 || dn !== 1'b0) begin
        n_fail++; $display("FAIL random_timing_%0d: latency %0d ready %b done %b", i, lat, rn, dn);
      end
    end
  endtask

  task automatic test_ignore_start();
    int ndone, done_at;
    logic [18:0] got, exp;
    logic [15:0] held;
    exp = model(16'h1111, 16'h2222, 1'b0);
    ndone = 0; done_at = -1; got = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    held = bus.result;
    for (int j = 1; j < 15; j++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++; done_at = j; got = {bus.result, bus.carry_out, bus.overflow, bus.zero};
      end else if (j < LAT) begin
        n_checks++;
        if (bus.result !== held) begin
          n_fail++; $display("FAIL run_result_stable_%0d: got %h required %h", j, bus.result, held);
        end
      end
      bus.start = (j == 1);
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = 1'($urandom);
    end
    bus.start = 1'b0;
    n_checks++;
    if (ndone !== 1 || done_at !== LAT) begin
      n_fail++; $display("FAIL ignore_done_count: %0d pulses at %0d required 1 at %0d", ndone, done_at, LAT);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL ignore_result: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone, lat; logic [18:0] got, exp; logic rd, rn, dn;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.result, bus.carry_out, bus.overflow, bus.zero} !== 19'h0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mid_run_reset: out %h ready %b done %b required 0/1/0",
                         {bus.result, bus.carry_out, bus.overflow, bus.zero}, bus.ready, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL stale_done: got %0d pulses required 0", ndone);
    end
    exp = model(16'hABCD, 16'h1234, 1'b1);
    run_op(16'hABCD, 16'h1234, 1'b1, lat, got, rd, rn, dn);
    n_checks++;
    if (got !== exp || lat !== LAT) begin
      n_fail++; $display("FAIL after_reset_op: got %h lat %0d required %h lat %0d", got, lat, exp, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp, got;
    logic [15:0] last_res;
    last_res = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (bus.done !== (i % 6 == 5)) begin
          n_fail++; $display("FAIL b2b_done_%0d: got %b required %b", i, bus.done, (i % 6 == 5));
        end
        if (bus.done) begin
          got = {bus.result, bus.carry_out, bus.overflow, bus.zero};
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
          last_res = bus.result;
          n_checks++;
          if (got !== exp) begin
            n_fail++; $display("FAIL b2b_result_%0d: got %h required %h", i, got, exp);
          end
        end else if (i > 5) begin
          n_checks++;
          if (bus.result !== last_res) begin
            n_fail++; $display("FAIL b2b_hold_%0d: got %h required %h", i, bus.result, last_res);
          end
        end
      end
      bus.start = (i < 29);
      bus.a = pick(); bus.b = pick(); bus.sub = 1'($urandom);
      if (i % 6 == 0) exp_q.push_back(model(bus.a, bus.b, bus.sub));
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b_leftover: %0d expected results not seen", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
